// File: rtl/ag_telemetry_uart.sv
// ag_telemetry_uart
// Snapshots sensor/actuator/status inputs into a 5-byte frame
//   {A5, sensors, status, seq, xor}
// and shifts it out LSB-first as UART 8N1 on uart_tx.
// A frame is launched by a periodic tick, by a change of the status byte,
// or by force_send. At most one further frame is held pending while busy.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | line idle high, waiting for a trigger or a pending frame
// S_START     | start bit (0) of the current byte
// S_DATA      | data bits of the current byte, LSB first
// S_STOP      | stop bit (1); then the next byte or the frame end
// S_FRAME_END | one cycle: frame_done pulse, sequence number advances
module ag_telemetry_uart #(
    parameter int CLKS_PER_BIT  = 217,
    parameter int REPORT_PERIOD = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] sensor_bits,
    input  logic [4:0] act_bits,
    input  logic       flag_fault,
    input  logic [1:0] crop_select,
    input  logic       force_send,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PER_W  = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(REPORT_PERIOD - 1);
    localparam logic [7:0]        SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_FRAME_END = 3'd4
    } state_t;

    state_t            state;
    state_t            state_d;

    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_d;
    logic [2:0]        byte_idx;
    logic [2:0]        byte_idx_d;

    logic [PER_W-1:0]  period_cnt;
    logic              period_hit;
    logic              pending;
    logic [7:0]        last_status;
    logic [7:0]        live_status;
    logic [7:0]        seq;

    logic [7:0]        snap_sensor;
    logic [7:0]        snap_status;
    logic [7:0]        snap_seq;
    logic [7:0]        checksum;
    logic [7:0]        byte_mux;

    logic              trigger;
    logic              bit_end;
    logic              launch;
    logic              tx_d;
    logic              busy_d;
    logic              done_d;

    assign live_status = {crop_select, flag_fault, act_bits};
    assign period_hit  = (period_cnt == PER_LAST);
    assign trigger     = force_send | period_hit | (live_status != last_status);
    assign bit_end     = (baud_cnt == '0);
    assign checksum    = SYNC_BYTE ^ snap_sensor ^ snap_status ^ snap_seq;

    // State register; everything freezes while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_d;
        end
    end

    // Next-state logic plus next values of the bit timer and bit/byte indices.
    always_comb begin
        state_d    = state;
        baud_d     = baud_cnt;
        bit_idx_d  = bit_idx;
        byte_idx_d = byte_idx;
        launch     = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger || pending) begin
                    state_d    = S_START;
                    launch     = 1'b1;
                    baud_d     = BAUD_LOAD;
                    bit_idx_d  = 3'd0;
                    byte_idx_d = 3'd0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    baud_d    = BAUD_LOAD;
                    bit_idx_d = 3'd0;
                end else begin
                    baud_d = baud_cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d    = BAUD_LOAD;
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = BAUD_LOAD;
                    if (byte_idx < 3'd4) begin
                        state_d    = S_START;
                        byte_idx_d = byte_idx + 3'd1;
                    end else begin
                        state_d = S_FRAME_END;
                    end
                end else begin
                    baud_d = baud_cnt - 1'b1;
                end
            end
            S_FRAME_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte selected for the next cycle's data bit.
    always_comb begin
        byte_mux = checksum;
        case (byte_idx_d)
            3'd0:    byte_mux = SYNC_BYTE;
            3'd1:    byte_mux = snap_sensor;
            3'd2:    byte_mux = snap_status;
            3'd3:    byte_mux = snap_seq;
            default: byte_mux = checksum;
        endcase
    end

    // Output values decoded from the next state so the pins come straight from flops.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            S_DATA: begin
                tx_d   = byte_mux[bit_idx_d];
                busy_d = 1'b1;
            end
            S_STOP: begin
                busy_d = 1'b1;
            end
            S_FRAME_END: begin
                done_d = 1'b1;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    // Datapath: bit timer, indices, period counter, snapshot, pending flag, sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt    <= '0;
            bit_idx     <= 3'd0;
            byte_idx    <= 3'd0;
            period_cnt  <= '0;
            pending     <= 1'b0;
            last_status <= 8'h00;
            seq         <= 8'h00;
            snap_sensor <= 8'h00;
            snap_status <= 8'h00;
            snap_seq    <= 8'h00;
            uart_tx     <= 1'b1;
            tx_busy     <= 1'b0;
            frame_done  <= 1'b0;
        end else if (ena) begin
            baud_cnt   <= baud_d;
            bit_idx    <= bit_idx_d;
            byte_idx   <= byte_idx_d;
            uart_tx    <= tx_d;
            tx_busy    <= busy_d;
            frame_done <= done_d;

            // Free-running period counter, independent of frame activity.
            if (period_hit) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 1'b1;
            end

            // A launch consumes the pending request; any trigger seen outside
            // IDLE (FRAME_END included) leaves exactly one frame pending.
            if (launch) begin
                snap_sensor <= sensor_bits;
                snap_status <= live_status;
                snap_seq    <= seq;
                last_status <= live_status;
                pending     <= 1'b0;
            end else if (trigger && (state != S_IDLE)) begin
                pending <= 1'b1;
            end

            if (state == S_FRAME_END) begin
                seq <= seq + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ag_telemetry_uart.sv
// Directed testbench for ag_telemetry_uart with CLKS_PER_BIT=4, REPORT_PERIOD=1000.
module tb_ag_telemetry_uart;

    localparam int CPB = 4;
    localparam int RP  = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] sensor_bits = 8'h00;
    logic [4:0] act_bits = 5'b00000;
    logic       flag_fault = 1'b0;
    logic [1:0] crop_select = 2'b00;
    logic       force_send = 1'b0;
    logic       uart_tx;
    logic       tx_busy;
    logic       frame_done;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic ena_q = 1'b1;

    ag_telemetry_uart #(
        .CLKS_PER_BIT (CPB),
        .REPORT_PERIOD(RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .sensor_bits(sensor_bits),
        .act_bits   (act_bits),
        .flag_fault (flag_fault),
        .crop_select(crop_select),
        .force_send (force_send),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Cycles since reset release, and the ena value each edge actually saw.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        ena_q <= ena;
    end

    // Waits (bounded) for a start bit, records the line until tx_busy drops and
    // decodes the 5 bytes. Samples taken after a stalled edge are skipped.
    // Returns at the first non-busy negedge (the frame-end cycle).
    task automatic rx_frame(input int timeout, output logic [39:0] frm,
                            output int busy_len, output int start_cyc, output bit ok);
        logic s [0:399];
        int   n;
        bit   seen;
        bit   fr_ok;
        frm = '0; busy_len = 0; start_cyc = -1; ok = 1'b0; n = 0; seen = 1'b0;
        for (int t = 0; t <= timeout; t++) begin
            if (uart_tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) return;
        start_cyc = cyc;
        while (tx_busy === 1'b1 && busy_len < 400) begin
            busy_len++;
            if (busy_len == 1 || ena_q === 1'b1) begin
                if (n < 400) s[n] = uart_tx;
                n++;
            end
            @(negedge clk);
        end
        if (n != 50 * CPB) return;
        fr_ok = 1'b1;
        for (int j = 0; j < 50; j++)
            for (int k = 1; k < CPB; k++)
                if (s[j*CPB+k] !== s[j*CPB]) fr_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (s[i*10*CPB] !== 1'b0) fr_ok = 1'b0;
            if (s[(i*10+9)*CPB] !== 1'b1) fr_ok = 1'b0;
            for (int k = 0; k < 8; k++) frm[i*8+k] = s[(i*10+1+k)*CPB];
        end
        ok = fr_ok;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_uart_tx got=%b want=1", uart_tx); end
        checks++;
        if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_tx_busy got=%b want=0", tx_busy); end
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    endtask

    task automatic test_first_frame();
        logic [39:0] frm;
        logic [39:0] exp_f;
        int bl, sc;
        bit ok;
        exp_f = {8'h7C, 8'h00, 8'h45, 8'h9C, 8'hA5};
        rst = 1'b0;
        sensor_bits = 8'h9C; act_bits = 5'b00101; flag_fault = 1'b0; crop_select = 2'b01;
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin failures++; $display("FAIL first_start_bit got=%b want=0", uart_tx); end
        checks++;
        if (tx_busy !== 1'b1) begin failures++; $display("FAIL first_busy got=%b want=1", tx_busy); end
        rx_frame(0, frm, bl, sc, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL first_framing got=%b want=1", ok); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (frm[8*i+:8] !== exp_f[8*i+:8]) begin
                failures++; $display("FAIL first_byte%0d got=%h want=%h", i, frm[8*i+:8], exp_f[8*i+:8]);
            end
        end
        checks++;
        if (bl != 200) begin failures++; $display("FAIL first_busy_len got=%0d want=200", bl); end
        checks++;
        if (frame_done !== 1'b1) begin failures++; $display("FAIL first_done_pulse got=%b want=1", frame_done); end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("FAIL first_done_single got=%b want=0", frame_done); end
    endtask

    task automatic test_periodic();
        logic [39:0] frm;
        logic [7:0]  m8;
        int bl, sc;
        bit ok;
        bit bad;
        for (int m = 1; m <= 3; m++) begin
            m8 = m[7:0];
            rx_frame(1100, frm, bl, sc, ok);
            checks++;
            if (ok !== 1'b1) begin failures++; $display("FAIL periodic%0d_framing got=%b want=1", m, ok); end
            checks++;
            if (sc != 1000 * m) begin failures++; $display("FAIL periodic%0d_start got=%0d want=%0d", m, sc, 1000 * m); end
            checks++;
            if (frm[31:24] !== m8) begin failures++; $display("FAIL periodic%0d_seq got=%h want=%h", m, frm[31:24], m8); end
            checks++;
            if (frm[39:32] !== (8'hA5 ^ 8'h9C ^ 8'h45 ^ m8)) begin
                failures++; $display("FAIL periodic%0d_csum got=%h want=%h", m, frm[39:32], 8'hA5 ^ 8'h9C ^ 8'h45 ^ m8);
            end
        end
        bad = 1'b0;
        while (cyc < 4000) begin
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin failures++; $display("FAIL periodic_no_extra got=activity want=idle"); end
    endtask

    task automatic test_busy_retrigger();
        logic [39:0] frm;
        int bl, sc;
        bit ok;
        bit bad;
        fork
            rx_frame(2, frm, bl, sc, ok);
            begin
                repeat (20) @(negedge clk);
                act_bits = 5'b00111;
                repeat (20) @(negedge clk);
                force_send = 1'b1;
                @(negedge clk);
                force_send = 1'b0;
                repeat (40) @(negedge clk);
                force_send = 1'b1;
                @(negedge clk);
                force_send = 1'b0;
            end
        join
        checks++;
        if (ok !== 1'b1 || frm[23:16] !== 8'h45 || frm[31:24] !== 8'h04) begin
            failures++; $display("FAIL busy_frame ok=%b b2=%h b3=%h want ok=1 b2=45 b3=04", ok, frm[23:16], frm[31:24]);
        end
        checks++;
        if (frame_done !== 1'b1) begin failures++; $display("FAIL busy_done got=%b want=1", frame_done); end
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL pending_gap got=%b want=1", uart_tx); end
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin failures++; $display("FAIL pending_start got=%b want=0", uart_tx); end
        rx_frame(0, frm, bl, sc, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL pending_framing got=%b want=1", ok); end
        checks++;
        if (frm[23:16] !== 8'h47) begin failures++; $display("FAIL pending_status got=%h want=47", frm[23:16]); end
        checks++;
        if (frm[31:24] !== 8'h05) begin failures++; $display("FAIL pending_seq got=%h want=05", frm[31:24]); end
        checks++;
        if (frm[39:32] !== 8'h7B) begin failures++; $display("FAIL pending_csum got=%h want=7B", frm[39:32]); end
        bad = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL pending_single got=second_frame want=idle"); end
    endtask

    task automatic test_seq_wrap();
        logic [39:0] frm;
        logic [7:0]  e;
        int bl, sc, r;
        bit ok;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i <= 256; i++) begin
            e = i[7:0];
            r = cyc % RP;
            if (uart_tx === 1'b0 || r >= 780 || r < 2) begin
                rx_frame(1100, frm, bl, sc, ok);
            end else begin
                force_send = 1'b1;
                @(negedge clk);
                force_send = 1'b0;
                rx_frame(2, frm, bl, sc, ok);
            end
            checks++;
            if (ok !== 1'b1) begin failures++; $display("FAIL wrap%0d_framing got=%b want=1", i, ok); end
            checks++;
            if (frm[31:24] !== e) begin failures++; $display("FAIL wrap%0d_seq got=%h want=%h", i, frm[31:24], e); end
            checks++;
            if (frm[39:32] !== (8'hA5 ^ 8'h9C ^ 8'h47 ^ e)) begin
                failures++; $display("FAIL wrap%0d_csum got=%h want=%h", i, frm[39:32], 8'hA5 ^ 8'h9C ^ 8'h47 ^ e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] frm;
        int bl, sc;
        bit ok;
        rst = 1'b1;
        sensor_bits = 8'h36;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        repeat (57) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin failures++; $display("FAIL abort_b1_bit3 got=%b want=0", uart_tx); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL abort_uart_tx got=%b want=1", uart_tx); end
        checks++;
        if (tx_busy !== 1'b0) begin failures++; $display("FAIL abort_tx_busy got=%b want=0", tx_busy); end
        rst = 1'b0;
        rx_frame(3, frm, bl, sc, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL abort_next_framing got=%b want=1", ok); end
        checks++;
        if (frm[31:24] !== 8'h00) begin failures++; $display("FAIL abort_next_seq got=%h want=00", frm[31:24]); end
        checks++;
        if (frm[15:8] !== 8'h36 || frm[39:32] !== (8'hA5 ^ 8'h36 ^ 8'h47)) begin
            failures++; $display("FAIL abort_next_bytes b1=%h b4=%h want b1=36 b4=%h", frm[15:8], frm[39:32], 8'hA5 ^ 8'h36 ^ 8'h47);
        end
        @(negedge clk);
    endtask

    task automatic test_ena_stall();
        logic [39:0] frm;
        int bl, sc;
        bit ok;
        bit bad;
        force_send = 1'b1;
        @(negedge clk);
        force_send = 1'b0;
        bad = 1'b0;
        fork
            rx_frame(0, frm, bl, sc, ok);
            begin
                repeat (117) @(negedge clk);
                ena = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (uart_tx !== 1'b1) bad = 1'b1;
                end
                ena = 1'b1;
            end
        join
        checks++;
        if (bad) begin failures++; $display("FAIL stall_hold got=low want=high"); end
        checks++;
        if (bl != 210) begin failures++; $display("FAIL stall_busy_len got=%0d want=210", bl); end
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL stall_framing got=%b want=1", ok); end
        checks++;
        if (frm[23:16] !== 8'h47 || frm[31:24] !== 8'h01) begin
            failures++; $display("FAIL stall_bytes b2=%h b3=%h want b2=47 b3=01", frm[23:16], frm[31:24]);
        end
        checks++;
        if (frame_done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b want=1", frame_done); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_periodic();
        test_busy_retrigger();
        test_seq_wrap();
        test_reset_mid_frame();
        test_ena_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
